// File: rtl/finger_count_sequencer.sv
// Finger-count sequencer: synchronises and debounces four finger switches,
// validates the stable pattern as a thermometer code and emits its 2-bit
// count once per gesture on a valid/ready handshake.
module finger_count_sequencer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             valid,
  input  logic             ready,
  output logic             y1,
  output logic             y0,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] accepted
);

  localparam int unsigned PAT_W = 4;
  localparam int unsigned DB_W  = $clog2(STABLE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    EMIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [PAT_W-1:0] sync1;
  logic [PAT_W-1:0] sync2;
  logic [PAT_W-1:0] ref_pat;
  logic [DB_W-1:0]  cnt;
  state_t           state;

  // A thermometer code is a non-empty run of ones filled from the LSB.
  function automatic logic is_legal(input logic [PAT_W-1:0] p);
    case (p)
      4'b0001, 4'b0011, 4'b0111, 4'b1111: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // Count of raised fingers minus one for legal codes.
  function automatic logic [1:0] finger_count(input logic [PAT_W-1:0] p);
    case (p)
      4'b0011: finger_count = 2'd1;
      4'b0111: finger_count = 2'd2;
      4'b1111: finger_count = 2'd3;
      default: finger_count = 2'd0;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous finger inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {a, b, c, d};
      sync2 <= sync1;
    end
  end

  // Debounce, legality check, one-shot emission and handshake sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ref_pat  <= '0;
      cnt      <= '0;
      valid    <= 1'b0;
      y1       <= 1'b0;
      y0       <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      accepted <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2 != '0) begin
            state   <= SETTLE;
            ref_pat <= sync2;
            cnt     <= DB_W'(1);
            busy    <= 1'b1;
          end
        end
        SETTLE: begin
          if (sync2 == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sync2 != ref_pat) begin
            ref_pat <= sync2;
            cnt     <= DB_W'(1);
          end else if (cnt == DB_LAST) begin
            if (is_legal(ref_pat)) begin
              state    <= EMIT;
              {y1, y0} <= finger_count(ref_pat);
              valid    <= 1'b1;
            end else begin
              state <= RELEASE;
              err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + DB_W'(1);
          end
        end
        EMIT: begin
          if (ready) begin
            state    <= RELEASE;
            valid    <= 1'b0;
            accepted <= accepted + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (sync2 == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_finger_count_sequencer.sv
// Bench for finger_count_sequencer: directed scenarios plus random finger
// activity, checked against a run-length based reference model. Two DUTs
// share stimulus so the gesture counter is also exercised at a 2-bit width.
module tb_finger_count_sequencer;

  localparam int unsigned STABLE = 4;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d, ready;
  logic valid, y1, y0, err, busy;
  logic [7:0] accepted;
  logic valid_w, y1_w, y0_w, err_w, busy_w;
  logic [1:0] accepted_w;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_s1, m_s2, run_val;
  int         run_len;
  bit         armed;
  logic       m_valid, m_err, m_busy;
  logic [1:0] m_y;
  int         m_acc;

  finger_count_sequencer #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .valid(valid), .ready(ready), .y1(y1), .y0(y0),
    .err(err), .busy(busy), .accepted(accepted)
  );

  finger_count_sequencer #(.STABLE_CYCLES(STABLE), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .valid(valid_w), .ready(ready), .y1(y1_w), .y0(y0_w),
    .err(err_w), .busy(busy_w), .accepted(accepted_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit thermo(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p + 4'd1)) == 4'd0);
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; run_val = '0; run_len = 0;
    armed = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    m_y = '0; m_acc = 0;
  endtask

  // One rising edge of the model: a gesture fires once its synchronised value
  // has been seen STABLE times in a row since the hand was last absent.
  task automatic model_edge();
    logic [3:0] s_pre;
    s_pre = m_s2;
    m_s2  = m_s1;
    m_s1  = {a, b, c, d};
    if (s_pre == run_val) run_len++;
    else begin
      run_val = s_pre;
      run_len = 1;
    end
    m_err = 1'b0;
    if (m_valid) begin
      if (ready) begin
        m_valid = 1'b0;
        m_acc++;
      end
    end else if (armed) begin
      if (s_pre != 4'd0 && run_len >= STABLE) begin
        armed = 1'b0;
        if (thermo(s_pre)) begin
          m_valid = 1'b1;
          m_y = 2'($countones(s_pre) - 1);
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (s_pre == 4'd0) begin
      armed = 1'b1;
    end
    m_busy = !(armed && s_pre == 4'd0);
  endtask

  task automatic compare_all();
    check("valid", 32'(valid), 32'(m_valid));
    check("y", 32'({y1, y0}), 32'(m_y));
    check("err", 32'(err), 32'(m_err));
    check("busy", 32'(busy), 32'(m_busy));
    check("accepted", 32'(accepted), 32'(m_acc % 256));
    check("accepted_w", 32'(accepted_w), 32'(m_acc % 4));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_p(input logic [3:0] p);
    {a, b, c, d} = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic release_hand();
    set_p(4'b0000);
    repeat (4) step();
  endtask

  initial begin
    int nv, ne;
    logic [1:0] wrap_exp [4];
    logic [3:0] pat;
    int hold;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0};

    rst = 1'b1; set_p(4'b0000); ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Two fingers held with ready high: emission on the sixth edge, one cycle
    set_p(4'b0011); ready = 1'b1;
    repeat (5) begin
      step();
      check("t1_no_valid_yet", 32'(valid), 32'd0);
    end
    step();
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_y", 32'({y1, y0}), 32'd1);
    step();
    check("t1_valid_drop", 32'(valid), 32'd0);
    check("t1_acc", 32'(accepted), 32'd1);
    nv = 0;
    repeat (20) begin
      step();
      if (valid) nv++;
    end
    check("t1_no_repeat", 32'(nv), 32'd0);
    release_hand();
    set_p(4'b1111);
    repeat (8) step();
    check("t1_y_four", 32'({y1, y0}), 32'd3);
    check("t1_acc2", 32'(accepted), 32'd2);

    // Bouncing fingers settle on three
    release_hand();
    nv = 0;
    set_p(4'b0001); repeat (2) begin step(); if (valid) nv++; end
    set_p(4'b0011); repeat (2) begin step(); if (valid) nv++; end
    set_p(4'b0111);
    repeat (12) begin step(); if (valid) nv++; end
    check("t2_one_valid", 32'(nv), 32'd1);
    check("t2_y", 32'({y1, y0}), 32'd2);

    // Illegal pattern: single err pulse, no valid
    release_hand();
    set_p(4'b0101);
    nv = 0; ne = 0;
    repeat (12) begin
      step();
      if (valid) nv++;
      if (err) ne++;
    end
    check("t3_err_pulses", 32'(ne), 32'd1);
    check("t3_no_valid", 32'(nv), 32'd0);
    set_p(4'b0000);
    step(); step();
    check("t3_busy_held", 32'(busy), 32'd1);
    step();
    check("t3_busy_clear", 32'(busy), 32'd0);

    // Backpressure: count frozen while consumer stalls
    repeat (2) step();
    ready = 1'b0;
    set_p(4'b0001);
    repeat (6) step();
    check("t4_valid", 32'(valid), 32'd1);
    check("t4_y", 32'({y1, y0}), 32'd0);
    set_p(4'b1111);
    repeat (5) step();
    check("t4_valid_hold", 32'(valid), 32'd1);
    check("t4_y_hold", 32'({y1, y0}), 32'd0);
    ready = 1'b1;
    step();
    check("t4_valid_drop", 32'(valid), 32'd0);
    check("t4_acc", 32'(accepted), 32'd4);
    release_hand();

    // Asynchronous reset while a count is pending
    ready = 1'b0;
    set_p(4'b0001);
    repeat (6) step();
    check("t5_pending", 32'(valid), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_valid_rst", 32'(valid), 32'd0);
    check("t5_y_rst", 32'({y1, y0}), 32'd0);
    check("t5_busy_rst", 32'(busy), 32'd0);
    check("t5_acc_rst", 32'(accepted), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready = 1'b1;
    repeat (8) step();
    check("t5_acc_after", 32'(accepted), 32'd1);

    // Narrow counter wraps after four handshakes
    set_p(4'b0000);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      release_hand();
      set_p(4'b0111);
      ready = 1'b1;
      repeat (7) step();
      check("t6_wrap", 32'(accepted_w), 32'(wrap_exp[i]));
    end
    release_hand();

    // Random finger activity with random backpressure
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: pat = 4'b0000;
        1: pat = 4'((1 << $urandom_range(1, 4)) - 1);
        default: pat = 4'($urandom_range(0, 15));
      endcase
      set_p(pat);
      hold = $urandom_range(1, 10);
      repeat (hold) begin
        ready = 1'($urandom_range(0, 1));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/finger_count_sequencer.md
Name: finger_count_sequencer

Overview:
Sequencer wrapped around the four-finger thermometer decoder datapath (fingers a,b,c,d -> 2-bit count y1,y0). It synchronises and debounces the raw finger inputs and checks that the stable pattern is a legal thermometer code. Each legal gesture is emitted exactly once as a 2-bit count on a valid/ready handshake. The block sits between the board finger switches and the downstream consumer, which is the display/ALU stage. It also keeps a wrap-around count of accepted gestures.

Parameters:
STABLE_CYCLES, 4, consecutive sampled cycles a non-zero pattern must hold before it is evaluated; legal range 2..255
CNT_W, 8, width of accepted-gesture counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
a  input  1  finger 3 (MSB of pattern), asynchronous to clk
b  input  1  finger 2
c  input  1  finger 1
d  input  1  finger 0 (LSB of pattern)
valid  output  1  count available on y1,y0
ready  input  1  consumer accepts count
y1  output  1  count bit 1
y0  output  1  count bit 0
err  output  1  one-cycle pulse: stable pattern was not a legal thermometer code
busy  output  1  high whenever state != IDLE
accepted  output  CNT_W  number of completed valid&ready handshakes, modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. While rst is high, all flops are cleared: synchroniser stages = 0, state = IDLE, cnt = 0, ref = 0, valid = 0, y1 = 0, y0 = 0, err = 0, busy = 0, accepted = 0. Reset during any state, including mid-handshake, aborts the operation; any pending count is dropped.
- Synchroniser: pattern P = {a,b,c,d}. P passes through 2 flops, giving S.
- Legal codes and mapping: 0001->00, 0011->01, 0111->10, 1111->11. 0000 means no hand. Every other value is illegal.
- IDLE:
  - If S != 0: go to SETTLE, ref <= S, cnt <= 1.
- SETTLE:
  - If S == 0: go to IDLE.
  - Else if S != ref: ref <= S, cnt <= 1 (restart debounce).
  - Else if cnt == STABLE_CYCLES-1 and ref is legal: go to EMIT, register {y1,y0} = map(ref), valid <= 1.
  - Else if cnt == STABLE_CYCLES-1 and ref is illegal: err <= 1 for exactly one cycle, go to RELEASE.
  - Else: cnt <= cnt + 1.
- EMIT:
  - valid stays high and y1,y0 stay constant until ready is sampled high. Input changes are ignored.
  - On valid&&ready: valid <= 0, accepted <= accepted + 1 (wraps from 2^CNT_W-1 to 0), go to RELEASE.
  - ready high while not in EMIT has no effect.
- RELEASE:
  - Stays here until S == 0 is sampled, then goes to IDLE. This guarantees one emission per gesture.
  - y1,y0 hold their last value. valid stays 0.
- Latency: P is stable from before rising edge 0. valid is high after edge STABLE_CYCLES+1, which is STABLE_CYCLES+2 edges total (6 edges for the default).
- Simultaneous events:
  - If ready is high in the same cycle valid rises, the handshake completes on the next edge (1-cycle minimum valid pulse).
  - S going to 0 on the final SETTLE cycle means IDLE takes priority; nothing is emitted.
- The debounce counter is $clog2(STABLE_CYCLES+1) bits wide and never exceeds STABLE_CYCLES-1.

Test Plan:
1. Reset, then a,b,c,d = 0,0,1,1 held, ready = 1 -> valid high for 1 cycle on edge 6, y1y0 = 01, accepted = 1. Keep fingers up for 20 cycles -> no second valid. Release to 0000, then 1111 -> y1y0 = 11, accepted = 2.
2. Bounce: 0001 for 2 cycles, then 0011 for 2 cycles, then 0111 held -> exactly one valid, y1y0 = 10. Its timing is measured from the last change.
3. Illegal pattern 0101 held -> err is a single-cycle pulse on edge 6, valid never asserts. Release to 0000 -> busy = 0 after 3 edges.
4. Backpressure: ready = 0, pattern 0001 -> valid = 1, y1y0 = 00. Change fingers to 1111 while waiting -> y1y0 stays 00. Raise ready -> valid drops on the next edge, accepted increments.
5. Async rst asserted between clock edges while in EMIT -> valid, y1,y0, busy and accepted are 0 immediately, before the next clock edge. After deassert, 0001 -> normal emission.
6. Wrap: CNT_W = 2, four handshakes -> accepted sequence 1, 2, 3, 0.
